out_port_rr_ctrl: RTL and testbench
===================================

OUT_PORT_RR_CTRL -- requirements
Module: out_port_rr_ctrl

Interface
REQ-001 Parameter NUM_IN, default 5, SHALL be the number of input channels competing for this output port (2..8).
REQ-002 Parameter PACKET_W, default 55, SHALL be the packet width in bits.
REQ-003 Parameter DATA_W, default 25, SHALL be the payload width at packet bits [DATA_W-1:0].
REQ-004 Parameter DIR_W, default 3, SHALL be the width of the direction field at bits [DATA_W+DIR_W-1:DATA_W].
REQ-005 Parameter DIRECTION, default 0 (DIR_W bits), SHALL be the direction code owned by this port.
REQ-006 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 pkt_in  input  NUM_IN*PACKET_W  packet heads; channel i occupies bits [i*PACKET_W +: PACKET_W].
REQ-009 valid_in  input  NUM_IN  channel i head is valid.
REQ-010 ack_in  output  NUM_IN  one-cycle pop pulse to channel i when its head is accepted.
REQ-011 full_dn  input  1  downstream FIFO full.
REQ-012 gnt_dn  input  1  downstream grant.
REQ-013 req_dn  output  1  request to downstream router.
REQ-014 pkt_out  output  PACKET_W  registered packet presented downstream.
REQ-015 busy  output  1  high while in WAIT_GNT.

Function
REQ-016 Channel i SHALL be a candidate when valid_in[i]=1 and its direction field equals DIRECTION.
REQ-017 FSM SHALL have two states: IDLE and WAIT_GNT.
REQ-018 In IDLE, with at least one candidate and full_dn=0, the block SHALL, on the same edge: select a winner, load pkt_out, set req_dn=1, pulse ack_in[winner] for exactly one cycle, and enter WAIT_GNT.
REQ-019 Winner selection SHALL be round-robin: the first candidate searched upward from (last_winner+1) mod NUM_IN, wrapping; after reset last_winner = NUM_IN-1, so channel 0 has first priority.
REQ-020 pkt_out SHALL be loaded as the winner's packet with the direction field forced to zero; all other bits SHALL pass unchanged.
REQ-021 In IDLE, with full_dn=1 or no candidates, the block SHALL hold state and keep all ack_in at 0, req_dn at 0, and pkt_out unchanged.
REQ-022 In WAIT_GNT, when gnt_dn=1, the block SHALL clear req_dn, update last_winner to the winner, and return to IDLE on the next edge; otherwise it SHALL hold req_dn=1 and pkt_out stable indefinitely.
REQ-023 Throughput SHALL be at most one packet per two cycles; a new acceptance SHALL NOT occur on the same edge that consumes gnt_dn.
REQ-024 gnt_dn while in IDLE SHALL be ignored.
REQ-025 full_dn changes during WAIT_GNT SHALL NOT affect req_dn or the state.
REQ-026 At most one ack_in bit SHALL be high in any cycle, and only in the cycle following an acceptance edge.
REQ-027 Candidates whose direction does not match SHALL never be acked, regardless of valid_in.

Reset
REQ-028 While reset=1, asynchronously: STATE=IDLE, req_dn=0, ack_in=0, busy=0, pkt_out=0, last_winner=NUM_IN-1.
REQ-029 Reset asserted during WAIT_GNT SHALL abandon the pending packet; no re-request after release.
REQ-030 The first acceptance SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-031 Single packet: reset release; valid_in=00001, ch0 direction=DIRECTION, full_dn=0 -> next edge req_dn=1, ack_in=00001 for one cycle, pkt_out direction field=0; gnt_dn=1 one cycle later -> req_dn=0, busy=0.
REQ-032 Round-robin: valid_in=10101 constant, all matching, gnt_dn returned each request -> winner order 0,2,4,0,2.
REQ-033 Direction filter: valid_in=11111, only ch3 matching -> only ack_in[3] ever pulses; others stay 0.
REQ-034 Backpressure: full_dn=1 with a matching candidate for 10 cycles -> req_dn=0, ack_in=0 throughout; full_dn=0 -> accept on next edge.
REQ-035 Grant stall/reset: in WAIT_GNT hold gnt_dn=0 for 20 cycles -> req_dn=1 and pkt_out stable; assert reset mid-wait -> req_dn=0 immediately (asynchronously), and after release ch0 again has first priority.
REQ-036 Edge cases: gnt_dn=1 pulsed in IDLE -> no effect; NUM_IN=2 build with valid_in=11 -> winners alternate 0,1,0,1.

Source files
------------

// File: rtl/out_port_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : out_port_rr_ctrl
// Description : Round-robin arbiter for one router output port; forwards the
//               winning channel head downstream and waits for the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module out_port_rr_ctrl #(
   parameter int               NUM_IN    = 5,
   parameter int               PACKET_W  = 55,
   parameter int               DATA_W    = 25,
   parameter int               DIR_W     = 3,
   parameter logic [DIR_W-1:0] DIRECTION = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_IN*PACKET_W-1:0] pkt_in,
   input  logic [NUM_IN-1:0]          valid_in,
   output logic [NUM_IN-1:0]          ack_in,
   input  logic                       full_dn,
   input  logic                       gnt_dn,
   output logic                       req_dn,
   output logic [PACKET_W-1:0]        pkt_out,
   output logic                       busy
);

   localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      WAIT_GNT = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic                w_accept;
   logic [IDX_W-1:0]    r_lastWinner;
   logic [IDX_W-1:0]    r_winner;
   logic [NUM_IN-1:0]   r_ack;
   logic [PACKET_W-1:0] r_pktOut;

   logic [PACKET_W-1:0] w_heads [NUM_IN];
   logic [NUM_IN-1:0]   w_cand;
   logic                w_found;
   logic [IDX_W-1:0]    w_winIdx;
   int                  w_idx;
   logic [PACKET_W-1:0] w_loadPkt;
   logic [NUM_IN-1:0]   w_winOneHot;

   generate
      for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
         assign w_heads[gi] = pkt_in[gi*PACKET_W +: PACKET_W];
         assign w_cand[gi]  = valid_in[gi] &&
                              (pkt_in[gi*PACKET_W + DATA_W +: DIR_W] == DIRECTION);
      end
   endgenerate

   // Search upward from the channel after the last granted winner, wrapping.
   always_comb begin
      w_found  = 1'b0;
      w_winIdx = '0;
      w_idx    = 0;
      for (int k = 1; k <= NUM_IN; k++) begin
         w_idx = int'(r_lastWinner) + k;
         if (w_idx >= NUM_IN) begin
            w_idx = w_idx - NUM_IN;
         end
         if (!w_found && w_cand[IDX_W'(w_idx)]) begin
            w_found  = 1'b1;
            w_winIdx = IDX_W'(w_idx);
         end
      end
   end

   // Downstream sees the packet with its routing field consumed.
   always_comb begin
      w_loadPkt                   = w_heads[w_winIdx];
      w_loadPkt[DATA_W +: DIR_W]  = '0;
      w_winOneHot                 = NUM_IN'(1) << w_winIdx;
   end

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_found && !full_dn) begin
               w_accept    = 1'b1;
               w_nextState = WAIT_GNT;
            end
         end
         WAIT_GNT: begin
            if (gnt_dn) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_ack        <= '0;
         r_pktOut     <= '0;
         r_winner     <= '0;
         r_lastWinner <= IDX_W'(NUM_IN - 1);
      end else begin
         r_state <= w_nextState;
         r_ack   <= w_accept ? w_winOneHot : '0;
         if (w_accept) begin
            r_pktOut <= w_loadPkt;
            r_winner <= w_winIdx;
         end
         // Priority only rotates once the packet has actually been granted.
         if (r_state == WAIT_GNT && gnt_dn) begin
            r_lastWinner <= r_winner;
         end
      end
   end

   assign ack_in  = r_ack;
   assign req_dn  = (r_state == WAIT_GNT);
   assign busy    = (r_state == WAIT_GNT);
   assign pkt_out = r_pktOut;

endmodule
`default_nettype wire

// File: tb/tb_out_port_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_out_port_rr_ctrl
// Description : Scoreboard bench for out_port_rr_ctrl (5-port and 2-port builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_out_port_rr_ctrl;

   localparam int         N    = 5;
   localparam int         PW   = 55;
   localparam logic [2:0] DIRC = 3'd5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic [N*PW-1:0] pktIn;
   logic [N-1:0]    validIn, ackIn;
   logic            fullDn, gntDn, reqDn, busy;
   logic [PW-1:0]   pktOut;

   logic [2*PW-1:0] pktIn2;
   logic [1:0]      validIn2, ackIn2;
   logic            fullDn2, gntDn2, reqDn2, busy2;
   logic [PW-1:0]   pktOut2;

   out_port_rr_ctrl #(.NUM_IN(N), .PACKET_W(PW), .DATA_W(25), .DIR_W(3), .DIRECTION(DIRC)) dut (
      .clk(clk), .reset(reset), .pkt_in(pktIn), .valid_in(validIn), .ack_in(ackIn),
      .full_dn(fullDn), .gnt_dn(gntDn), .req_dn(reqDn), .pkt_out(pktOut), .busy(busy));

   out_port_rr_ctrl #(.NUM_IN(2)) dut2 (
      .clk(clk), .reset(reset), .pkt_in(pktIn2), .valid_in(validIn2), .ack_in(ackIn2),
      .full_dn(fullDn2), .gnt_dn(gntDn2), .req_dn(reqDn2), .pkt_out(pktOut2), .busy(busy2));

   typedef struct {
      logic [7:0]    ack;
      logic [PW-1:0] pkt;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [PW-1:0] mkPkt(int ch, logic [2:0] dir);
      logic [26:0] hi;
      logic [24:0] lo;
      hi = 27'h3A5_0000 + 27'(ch);
      lo = 25'h15_5000 + 25'(ch * 3);
      return {hi, dir, lo};
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic setHead(int ch, logic [2:0] dir);
      pktIn[ch*PW +: PW] = mkPkt(ch, dir);
   endtask

   task automatic push1(int ch);
      exp_t e;
      e.ack = 8'(1 << ch);
      e.pkt = mkPkt(ch, 3'd0);
      q1.push_back(e);
   endtask

   task automatic push2(int ch);
      exp_t e;
      e.ack = 8'(1 << ch);
      e.pkt = mkPkt(ch, 3'd0);
      q2.push_back(e);
   endtask

   // Grant n requests; the last grant also withdraws all heads.
   task automatic serve(int n, bit two);
      for (int i = 0; i < n; i++) begin
         int w;
         w = 0;
         while (((two ? reqDn2 : reqDn) !== 1'b1) && w < 30) begin
            @(negedge clk);
            w++;
         end
         if (w >= 30) begin
            total++;
            bad++;
            $display("FAIL serve_timeout: got no req_dn expected req_dn=1 (grant %0d)", i);
            return;
         end
         if (two) gntDn2 = 1'b1; else gntDn = 1'b1;
         if (i == n - 1) begin
            if (two) validIn2 = '0; else validIn = '0;
         end
         @(negedge clk);
         gntDn  = 1'b0;
         gntDn2 = 1'b0;
      end
   endtask

   always @(negedge clk) begin : mon1
      exp_t e;
      if (ackIn !== '0) begin
         if (q1.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ack1_unexpected: got ack=%b expected none", ackIn);
         end else begin
            e = q1.pop_front();
            check("ack1_pkt_req", 64'({ackIn, pktOut, reqDn}), 64'({e.ack[N-1:0], e.pkt, 1'b1}));
         end
      end
   end

   always @(negedge clk) begin : mon2
      exp_t e;
      if (ackIn2 !== '0) begin
         if (q2.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ack2_unexpected: got ack=%b expected none", ackIn2);
         end else begin
            e = q2.pop_front();
            check("ack2_pkt_req", 64'({ackIn2, pktOut2, reqDn2}), 64'({e.ack[1:0], e.pkt, 1'b1}));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; validIn = '0; gntDn = 1'b0; fullDn = 1'b0;
      validIn2 = '0; gntDn2 = 1'b0; fullDn2 = 1'b0;
      for (int c = 0; c < N; c++) setHead(c, 3'd1);
      pktIn2 = {mkPkt(1, 3'd0), mkPkt(0, 3'd0)};
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_req", 64'(reqDn), 64'(0));
      check("rst_ack", 64'(ackIn), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_pkt", 64'(pktOut), 64'(0));

      // Single packet accepted on the first edge after reset release.
      setHead(0, DIRC);
      validIn = 5'b00001;
      push1(0);
      reset = 1'b0;
      @(negedge clk);
      check("first_req", 64'(reqDn), 64'(1));
      validIn = '0;
      @(negedge clk);
      check("ack_one_cycle", 64'(ackIn), 64'(0));
      check("busy_wait", 64'(busy), 64'(1));
      serve(1, 1'b0);
      check("gnt_req_clear", 64'(reqDn), 64'(0));
      check("gnt_busy_clear", 64'(busy), 64'(0));

      // Round-robin from fresh reset: 0,2,4,0,2.
      reset = 1'b1;
      @(negedge clk);
      for (int c = 0; c < N; c++) setHead(c, DIRC);
      validIn = 5'b10101;
      push1(0); push1(2); push1(4); push1(0); push1(2);
      reset = 1'b0;
      serve(5, 1'b0);

      // Direction filter: only ch3 matches.
      for (int c = 0; c < N; c++) setHead(c, 3'd1);
      setHead(3, DIRC);
      validIn = 5'b11111;
      push1(3); push1(3); push1(3);
      serve(3, 1'b0);

      // Backpressure.
      setHead(1, DIRC);
      fullDn  = 1'b1;
      validIn = 5'b00010;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_req", 64'(reqDn), 64'(0));
         check("bp_ack", 64'(ackIn), 64'(0));
      end
      push1(1);
      fullDn = 1'b0;
      @(negedge clk);
      check("bp_release_req", 64'(reqDn), 64'(1));
      validIn = '0;

      // Grant stall with full_dn toggling, then async reset mid-wait.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         fullDn = i[0];
         check("stall_req", 64'(reqDn), 64'(1));
         check("stall_pkt", 64'(pktOut), 64'(mkPkt(1, 3'd0)));
      end
      fullDn = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("async_rst_req", 64'(reqDn), 64'(0));
      check("async_rst_busy", 64'(busy), 64'(0));
      setHead(0, DIRC);
      setHead(4, DIRC);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("no_rereq", 64'(reqDn), 64'(0));
      validIn = 5'b10001;
      push1(0);
      serve(1, 1'b0);

      // Grant while idle has no effect.
      gntDn = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_gnt_req", 64'(reqDn), 64'(0));
      check("idle_gnt_busy", 64'(busy), 64'(0));
      check("idle_gnt_pkt", 64'(pktOut), 64'(mkPkt(0, 3'd0)));
      gntDn = 1'b0;
      validIn = 5'b10001;
      push1(4);
      serve(1, 1'b0);

      // Two-input build alternates.
      validIn2 = 2'b11;
      push2(0); push2(1); push2(0); push2(1);
      serve(4, 1'b1);

      repeat (3) @(negedge clk);
      check("q1_drained", 64'(q1.size()), 64'(0));
      check("q2_drained", 64'(q2.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
